// File: rtl/gpr_mp_if.sv
// ---------------------------------------------------------------------------
// gpr_mp_if
// Bundles the traffic of the multi-port register file: read addresses and
// read results, the two writeback lanes, the issue (busy-marking) request
// and the ready flag from the post-reset clear sequencer.
//
// Parameters: XLEN (register width), DEPTH (register count), NRP (read ports)
// Signals:
//   ready      file has finished clearing and accepts traffic
//   rs         NRP packed read addresses, port i at [i*AW +: AW]
//   pre_rrs    combinational forwarded read data, port i at [i*XLEN +: XLEN]
//   rrs        pre_rrs registered one cycle
//   rs_busy    per read port: source still waiting on a producer
//   we0/rd0/rrd0  writeback lane 0
//   we1/rd1/rrd1  writeback lane 1 (wins on address collisions)
//   iss_valid/iss_rd  issue request marking iss_rd busy
// Modports: master = decode/writeback side, slave = register file.
// ---------------------------------------------------------------------------
interface gpr_mp_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 32,
    parameter int NRP   = 2
);
    localparam int AW = $clog2(DEPTH);

    logic                 ready;
    logic [NRP*AW-1:0]    rs;
    logic [NRP*XLEN-1:0]  pre_rrs;
    logic [NRP*XLEN-1:0]  rrs;
    logic [NRP-1:0]       rs_busy;
    logic                 we0;
    logic [AW-1:0]        rd0;
    logic [XLEN-1:0]      rrd0;
    logic                 we1;
    logic [AW-1:0]        rd1;
    logic [XLEN-1:0]      rrd1;
    logic                 iss_valid;
    logic [AW-1:0]        iss_rd;

    modport master (
        input  ready, pre_rrs, rrs, rs_busy,
        output rs, we0, rd0, rrd0, we1, rd1, rrd1, iss_valid, iss_rd
    );

    modport slave (
        output ready, pre_rrs, rrs, rs_busy,
        input  rs, we0, rd0, rrd0, we1, rd1, rrd1, iss_valid, iss_rd
    );
endinterface

// File: rtl/gpr_mp.sv
// ---------------------------------------------------------------------------
// gpr_mp
// Multi-port general purpose register file. NRP read ports with write-through
// forwarding (combinational pre_rrs, registered rrs), two writeback lanes with
// lane 1 taking priority, a per-register busy scoreboard fed by issue, and a
// clear sequencer that zeroes every register after reset before ready rises.
// Register 0 is hardwired to zero and is never busy.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    gpr_mp_if slave modport (reads, writes, issue, ready)
// ---------------------------------------------------------------------------
module gpr_mp #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 32,
    parameter int NRP   = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    gpr_mp_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t               state, state_next;
    logic [AW-1:0]        clr_idx, clr_idx_next;
    logic [XLEN-1:0]      regs [DEPTH];
    logic [DEPTH-1:0]     busy, busy_next;
    logic [NRP*XLEN-1:0]  pre_rrs_c;
    logic [NRP-1:0]       rs_busy_c;
    logic                 wr0, wr1, iss;
    logic                 running;

    // Traffic only counts once the clear sequence is over; writes and issue
    // aimed at register 0 are dropped here so nothing downstream sees them.
    assign running = (state == RUN);
    assign wr0     = running && bus.we0 && (bus.rd0 != '0);
    assign wr1     = running && bus.we1 && (bus.rd1 != '0);
    assign iss     = running && bus.iss_valid && (bus.iss_rd != '0);

    // Forwarded value for one read address: lane 1 beats lane 0 beats the array.
    function automatic logic [XLEN-1:0] fwd(input logic [AW-1:0] addr);
        if (addr == '0)
            return '0;
        else if (wr1 && bus.rd1 == addr)
            return bus.rrd1;
        else if (wr0 && bus.rd0 == addr)
            return bus.rrd0;
        else
            return regs[addr];
    endfunction

    function automatic logic written(input logic [AW-1:0] addr);
        return (wr0 && bus.rd0 == addr) || (wr1 && bus.rd1 == addr);
    endfunction

    // State register for the clear sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_next;
            clr_idx <= clr_idx_next;
        end
    end

    // Walk clr_idx through every register once; the last clear write moves
    // the FSM to RUN, where it stays until the next reset.
    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        unique case (state)
            CLEAR: begin
                if (clr_idx == AW'(DEPTH - 1))
                    state_next = RUN;
                else
                    clr_idx_next = clr_idx + AW'(1);
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // Storage is not reset; the clear sequencer initialises it. Lane 1 is
    // written last so it wins when both lanes target the same register.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            regs[clr_idx] <= '0;
        end else begin
            if (wr0)
                regs[bus.rd0] <= bus.rrd0;
            if (wr1)
                regs[bus.rd1] <= bus.rrd1;
        end
    end

    // Retirement clears busy, issue sets it; the set is applied last because
    // a newly issued producer supersedes the one retiring this cycle.
    always_comb begin
        busy_next = busy;
        if (wr0)
            busy_next[bus.rd0] = 1'b0;
        if (wr1)
            busy_next[bus.rd1] = 1'b0;
        if (iss)
            busy_next[bus.iss_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy <= '0;
        else
            busy <= busy_next;
    end

    // Per-port read data and busy view; both read as zero while clearing.
    // A source being written this cycle is no longer waiting on its producer.
    always_comb begin
        pre_rrs_c = '0;
        rs_busy_c = '0;
        for (int i = 0; i < NRP; i++) begin
            if (running) begin
                pre_rrs_c[i*XLEN +: XLEN] = fwd(bus.rs[i*AW +: AW]);
                rs_busy_c[i] = busy[bus.rs[i*AW +: AW]]
                             & ~written(bus.rs[i*AW +: AW])
                             & (bus.rs[i*AW +: AW] != '0);
            end
        end
    end

    // Registered copy of the forwarded data, captured on every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.rrs <= '0;
        else
            bus.rrs <= pre_rrs_c;
    end

    assign bus.pre_rrs = pre_rrs_c;
    assign bus.rs_busy = rs_busy_c;
    assign bus.ready   = running;

endmodule

// File: tb/tb_gpr_mp.sv
// ---------------------------------------------------------------------------
// tb_gpr_mp
// Directed bench for gpr_mp. The stimulus process drives one cycle at a time
// and queues the responses it expects (combinational ones for this cycle,
// registered ones for the next); a separate monitor at each falling edge
// takes every entry due that cycle and compares it with the DUT.
// ---------------------------------------------------------------------------
module tb_gpr_mp;
    localparam int XLEN  = 32;
    localparam int DEPTH = 32;
    localparam int NRP   = 2;

    localparam int K_PRE   = 0;
    localparam int K_RRS   = 1;
    localparam int K_BUSY  = 2;
    localparam int K_READY = 3;

    typedef struct {
        int          due;
        int          kind;
        int          port;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   fails;
    exp_t sb[$];

    gpr_mp_if #(.XLEN(XLEN), .DEPTH(DEPTH), .NRP(NRP)) bus ();

    gpr_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NRP(NRP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kindName(input int kind);
        case (kind)
            K_PRE:   return "pre_rrs";
            K_RRS:   return "rrs";
            K_BUSY:  return "rs_busy";
            default: return "ready";
        endcase
    endfunction

    task automatic pushExp(input int due, input int kind, input int port, input logic [31:0] exp);
        exp_t e;
        e.due  = due;
        e.kind = kind;
        e.port = port;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [31:0] act;
        case (e.kind)
            K_PRE:   act = bus.pre_rrs[e.port*XLEN +: XLEN];
            K_RRS:   act = bus.rrs[e.port*XLEN +: XLEN];
            K_BUSY:  act = {31'b0, bus.rs_busy[e.port]};
            default: act = {31'b0, bus.ready};
        endcase
        checks++;
        if (act !== e.exp) begin
            fails++;
            $display("[TB] FAIL %s[%0d] cycle %0d: got %h expected %h",
                     kindName(e.kind), e.port, cyc, act, e.exp);
        end
    endtask

    // Monitor: compare everything due this cycle; anything overdue is a miss.
    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due == cyc) begin
                checkOutput(sb[i]);
                sb.delete(i);
            end else if (sb[i].due < cyc) begin
                checks++;
                fails++;
                $display("[TB] FAIL %s[%0d] never checked: due cycle %0d, now %0d",
                         kindName(sb[i].kind), sb[i].port, sb[i].due, cyc);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of traffic and queue what must come back: read data and
    // busy this cycle, the registered read data one cycle later.
    task automatic applyStimulus(
        input logic w0, input logic [4:0] a0, input logic [31:0] d0,
        input logic w1, input logic [4:0] a1, input logic [31:0] d1,
        input logic iv, input logic [4:0] ir,
        input logic [4:0] r0, input logic [4:0] r1,
        input logic [31:0] e0, input logic [31:0] e1,
        input logic b0, input logic b1
    );
        bus.we0 = w0; bus.rd0 = a0; bus.rrd0 = d0;
        bus.we1 = w1; bus.rd1 = a1; bus.rrd1 = d1;
        bus.iss_valid = iv; bus.iss_rd = ir;
        bus.rs = {r1, r0};
        pushExp(cyc, K_PRE, 0, e0);
        pushExp(cyc, K_PRE, 1, e1);
        pushExp(cyc, K_BUSY, 0, {31'b0, b0});
        pushExp(cyc, K_BUSY, 1, {31'b0, b1});
        pushExp(cyc + 1, K_RRS, 0, e0);
        pushExp(cyc + 1, K_RRS, 1, e1);
        step();
    endtask

    task automatic idleCycle(input logic [4:0] r0, input logic [4:0] r1,
                             input logic [31:0] e0, input logic [31:0] e1,
                             input logic b0, input logic b1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, r0, r1, e0, e1, b0, b1);
    endtask

    // Release reset and follow the clear: ready low for 32 cycles, then high.
    // A write and an issue to r9 are injected after r9 has been cleared; both
    // must be ignored.
    task automatic clearSequence();
        logic [4:0] k5;
        rst_n = 1'b1;
        for (int k = 0; k <= DEPTH; k++) begin
            k5 = k[4:0];
            pushExp(cyc, K_READY, 0, (k == DEPTH) ? 32'd1 : 32'd0);
            if (k == 20)
                applyStimulus(1, 9, 32'hDEAD_BEEF, 1, 9, 32'hCAFE_F00D, 1, 9, 9, k5, 0, 0, 0, 0);
            else
                idleCycle(9, k5, 0, 0, 0, 0);
        end
    endtask

    initial begin
        int t0;
        rst_n = 1'b0;
        cyc = 0; checks = 0; fails = 0;
        bus.we0 = 0; bus.rd0 = 0; bus.rrd0 = 0;
        bus.we1 = 0; bus.rd1 = 0; bus.rrd1 = 0;
        bus.iss_valid = 0; bus.iss_rd = 0; bus.rs = '0;
        step();
        step();

        // Held in reset: not ready, outputs zero.
        for (int k = 0; k < 3; k++) begin
            pushExp(cyc, K_READY, 0, 0);
            idleCycle(1, 2, 0, 0, 0, 0);
        end

        // Release, then reset again after 10 cycles of clearing.
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            pushExp(cyc, K_READY, 0, 0);
            idleCycle(3, 4, 0, 0, 0, 0);
        end
        rst_n = 1'b0;
        pushExp(cyc, K_READY, 0, 0);
        idleCycle(3, 4, 0, 0, 0, 0);

        clearSequence();

        //            w0 a0  d0            w1 a1  d1            iv ir  r0  r1  e0            e1            b0 b1
        idleCycle(                                                    1, 31, 0,            0,            0, 0);
        applyStimulus(1, 5,  32'hA5A5A5A5, 0, 0,  0,            0, 0,  5,  0,  32'hA5A5A5A5, 0,            0, 0);
        idleCycle(                                                    5,  5, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0);
        applyStimulus(1, 7,  32'h1,        1, 7,  32'h2,        0, 0,  7,  7,  32'h2,        32'h2,        0, 0);
        idleCycle(                                                    7,  5, 32'h2,        32'hA5A5A5A5, 0, 0);
        applyStimulus(0, 0,  0,            1, 0,  32'hFFFFFFFF, 1, 0,  0,  0,  0,            0,            0, 0);
        idleCycle(                                                    0,  0, 0,            0,            0, 0);
        applyStimulus(1, 10, 32'h10,       1, 11, 32'h11,       0, 0,  10, 11, 32'h10,       32'h11,       0, 0);
        applyStimulus(0, 0,  0,            0, 0,  0,            1, 3,  3,  3,  0,            0,            0, 0);
        idleCycle(                                                    3,  4, 0,            0,            1, 0);
        applyStimulus(1, 3,  32'h33,       0, 0,  0,            0, 0,  3,  3,  32'h33,       32'h33,       0, 0);
        idleCycle(                                                    3,  3, 32'h33,       32'h33,       0, 0);
        applyStimulus(0, 0,  0,            1, 4,  32'h44,       1, 4,  4,  3,  32'h44,       32'h33,       0, 0);
        idleCycle(                                                    4,  4, 32'h44,       32'h44,       1, 1);
        applyStimulus(1, 9,  32'h99,       0, 0,  0,            0, 0,  4,  9,  32'h44,       32'h99,       1, 0);
        applyStimulus(0, 0,  0,            1, 4,  32'h45,       0, 0,  4,  4,  32'h45,       32'h45,       0, 0);
        idleCycle(                                                    4,  4, 32'h45,       32'h45,       0, 0);
        applyStimulus(1, 6,  32'h66,       0, 0,  0,            1, 6,  6,  6,  32'h66,       32'h66,       0, 0);
        idleCycle(                                                    6,  5, 32'h66,       32'hA5A5A5A5, 1, 0);
        applyStimulus(1, 5,  32'h55,       1, 5,  32'h56,       0, 0,  5,  6,  32'h56,       32'h66,       0, 1);
        idleCycle(                                                    5, 11, 32'h56,       32'h11,       0, 0);
        idleCycle(                                                    6,  6, 32'h66,       32'h66,       1, 1);
        idleCycle(                                                    0,  0, 0,            0,            0, 0);

        // Reset from RUN: busy and contents are gone after the new clear.
        rst_n = 1'b0;
        pushExp(cyc, K_READY, 0, 0);
        idleCycle(6, 5, 0, 0, 0, 0);
        clearSequence();
        idleCycle(6, 5, 0, 0, 0, 0);
        idleCycle(0, 0, 0, 0, 0, 0);

        // Give the monitor a bounded window to drain the scoreboard.
        t0 = cyc;
        while (sb.size() > 0 && cyc - t0 < 5)
            step();
        if (sb.size() > 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
